// File: rtl/mips_pkg.sv
// Shared fetch-stage types and constants.
// Holds the fetch FSM state enum, datapath widths, the PC step, and a
// word-alignment helper used by the PC register and the fetch control.
package mips_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned INSTR_W = 32;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    // Clear the byte-offset bits so an address points at a whole word.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] i_addr);
        return {i_addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/grant/response,
// decode-side valid/ready with instruction, PC and PC+4, and the redirect
// port. master = fetch stage, slave = memory/decode/branch side.
interface instr_fetch_if;
    import mips_pkg::*;

    logic                 o_imem_req;
    logic [XLEN-1:0]      o_imem_addr;
    logic                 i_imem_gnt;
    logic                 i_imem_rvalid;
    logic [INSTR_W-1:0]   i_imem_rdata;
    logic                 o_valid;
    logic                 i_ready;
    logic [INSTR_W-1:0]   o_instr;
    logic [XLEN-1:0]      o_pc;
    logic [XLEN-1:0]      o_pc_plus4;
    logic                 i_redirect;
    logic [XLEN-1:0]      i_redirect_pc;

    modport master (
        output o_imem_req, o_imem_addr,
        input  i_imem_gnt, i_imem_rvalid, i_imem_rdata,
        output o_valid, o_instr, o_pc, o_pc_plus4,
        input  i_ready,
        input  i_redirect, i_redirect_pc
    );

    modport slave (
        input  o_imem_req, o_imem_addr,
        output i_imem_gnt, i_imem_rvalid, i_imem_rdata,
        input  o_valid, o_instr, o_pc, o_pc_plus4,
        output i_ready,
        output i_redirect, i_redirect_pc
    );

endinterface

// File: rtl/pc_reg.sv
// Program counter register with asynchronous reset.
// Ports: i_clk, i_rst (async, active-high), i_redirect/i_redirect_pc (load a
// new target, low bits forced to 0), i_inc (advance by one word), o_pc.
// Priority: redirect > increment > hold.
module pc_reg
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    input  logic            i_inc,
    output logic [XLEN-1:0] o_pc
);

    logic [XLEN-1:0] r_pc;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc <= RESET_PC;
        end else if (i_redirect) begin
            r_pc <= word_align(i_redirect_pc);
        end else if (i_inc) begin
            r_pc <= r_pc + PC_STEP;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues one word-aligned read at a
// time to instruction memory, and holds the returned word for decode.
// Ports: i_clk, i_rst (async, active-high), io_fetch (instr_fetch_if.master:
// imem req/addr/gnt/rvalid/rdata, decode valid/ready/instr/pc/pc_plus4,
// redirect/redirect_pc). Parameter RESET_PC is the word-aligned boot address.
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic          i_clk,
    input  logic          i_rst,
    instr_fetch_if.master io_fetch
);

    fetch_state_t       r_state;
    logic               r_drop;
    logic [INSTR_W-1:0] r_instr;
    logic [XLEN-1:0]    r_pc_out;
    logic [XLEN-1:0]    r_pc_plus4;

    logic [XLEN-1:0]    w_pc;
    logic               w_accept_rsp;
    logic               w_inc;

    // A response is kept only if nothing has flushed it: neither an earlier
    // redirect (drop) nor one arriving on the same edge.
    assign w_accept_rsp = (r_state == WAIT) && io_fetch.i_imem_rvalid
                          && !r_drop && !io_fetch.i_redirect;
    assign w_inc        = w_accept_rsp;

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_redirect    (io_fetch.i_redirect),
        .i_redirect_pc (io_fetch.i_redirect_pc),
        .i_inc         (w_inc),
        .o_pc          (w_pc)
    );

    // Fetch control and the held instruction/PC registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_drop     <= 1'b0;
            r_instr    <= '0;
            r_pc_out   <= RESET_PC;
            r_pc_plus4 <= RESET_PC + PC_STEP;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= REQ;
                end
                REQ: begin
                    // A grant alongside a redirect still launches the old
                    // read, so its response must be thrown away.
                    if (io_fetch.i_imem_gnt) begin
                        r_state <= WAIT;
                        r_drop  <= io_fetch.i_redirect;
                    end
                end
                WAIT: begin
                    if (io_fetch.i_imem_rvalid) begin
                        r_drop <= 1'b0;
                        if (w_accept_rsp) begin
                            r_state    <= HOLD;
                            r_instr    <= io_fetch.i_imem_rdata;
                            r_pc_out   <= w_pc;
                            r_pc_plus4 <= w_pc + PC_STEP;
                        end else begin
                            r_state <= REQ;
                        end
                    end else if (io_fetch.i_redirect) begin
                        r_drop <= 1'b1;
                    end
                end
                HOLD: begin
                    if (io_fetch.i_ready || io_fetch.i_redirect) begin
                        r_state <= REQ;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Bus outputs are decoded from registered state and PC only.
    assign io_fetch.o_imem_req  = (r_state == REQ);
    assign io_fetch.o_imem_addr = w_pc;
    assign io_fetch.o_valid     = (r_state == HOLD);
    assign io_fetch.o_instr     = r_instr;
    assign io_fetch.o_pc        = r_pc_out;
    assign io_fetch.o_pc_plus4  = r_pc_plus4;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage. Owns the program counter, issues one word-aligned read at a time to instruction memory over a request/grant + response-valid handshake, and holds each returned 32-bit instruction word for the decode stage. Its output word drives the field splitter that feeds the instruction decoder and ALU. Branch/jump targets computed downstream come back on a redirect port, which flushes any stale fetch.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; bits [1:0] must be 0.
- `i_clk` in 1: clock, rising edge.
- `i_rst` in 1: asynchronous, active-high reset.
- `o_imem_req` out 1: read request valid.
- `o_imem_addr` out 32: byte address of the request, always word-aligned.
- `i_imem_gnt` in 1: memory accepted the request this cycle.
- `i_imem_rvalid` in 1: read data valid.
- `i_imem_rdata` in 32: instruction word.
- `o_valid` out 1: `o_instr`/`o_pc` hold a fetched instruction.
- `i_ready` in 1: decode accepts the instruction this cycle.
- `o_instr` out 32: instruction word, fed to the splitter.
- `o_pc` out 32: address of `o_instr`.
- `o_pc_plus4` out 32: `o_pc`+4, mod 2^32.
- `i_redirect` in 1: load new PC and flush.
- `i_redirect_pc` in 32: redirect target; bits [1:0] are ignored and forced to 0.

## Operation
- States:
  - IDLE: reset only.
  - REQ: `o_imem_req`=1, `o_imem_addr`=pc.
  - WAIT: granted, awaiting rvalid.
  - HOLD: `o_valid`=1.
- Transitions:
  - IDLE→REQ unconditionally on the first clock after reset is released.
  - REQ→WAIT on `i_imem_gnt`.
  - WAIT→HOLD on `i_imem_rvalid` with drop=0. The same edge loads `o_instr`←rdata and `o_pc`←pc, then pc←pc+4.
  - WAIT→REQ on `i_imem_rvalid` with drop=1. The response is discarded and drop is cleared.
  - HOLD→REQ when `o_valid && i_ready`.
- Redirect, which has the highest priority and may arrive in any non-reset state:
  - pc←{`i_redirect_pc`[31:2],2'b00}.
  - IDLE/REQ without gnt: go to REQ. A request raised this cycle with the old address counts only if gnt is high.
  - REQ with gnt in the same cycle: go to WAIT with drop=1.
  - WAIT without rvalid: stay in WAIT and set drop=1.
  - WAIT with rvalid in the same cycle: discard the data and go to REQ.
  - HOLD: go to REQ and drop `o_valid`. If `i_ready` was also high, the transfer counts as accepted.
- Only one request is outstanding; no new request is issued before the response to the current one arrives.
- PC arithmetic is 32-bit unsigned. 32'hFFFF_FFFC+4 wraps to 0.
- `o_instr`, `o_pc` and `o_pc_plus4` are stable while `o_valid`=1 and not yet accepted.
- An `i_imem_rvalid` outside WAIT is ignored.

## Timing
- Reset values:
  - state=IDLE, pc=`RESET_PC`, drop=0.
  - `o_imem_req`=0, `o_valid`=0.
  - `o_instr`=0, `o_pc`=`RESET_PC`, `o_pc_plus4`=`RESET_PC`+4.
- Reset asserted mid-operation aborts everything asynchronously. A later rvalid for the aborted request arrives in REQ and is ignored.
- `o_imem_req`, `o_imem_addr` and `o_valid` are decoded from registered state and pc only. There are no combinational paths from inputs to outputs.
- Latency: a grant at edge N with rvalid at N+k gives `o_valid`=1 from edge N+k. The minimum loop is 3 cycles per instruction with zero-wait memory (REQ, WAIT, HOLD).
- After a redirect at edge R, the new address appears on `o_imem_addr` from R, or from the drop-response edge if a fetch was in flight.

## Structure
- Shared package `mips_pkg` holds:
  - `fetch_state_t` enum {IDLE, REQ, WAIT, HOLD};
  - `XLEN`=32 and `INSTR_W`=32;
  - `PC_STEP`=4.
- `RESET_PC` stays a module parameter.
- One sub-module, `pc_reg`, is natural. It holds the async-reset PC register with a load/increment/redirect mux, redirect > increment > hold.

## Test plan
- Reset release with `RESET_PC`=0:
  - Zero-wait memory, gnt=1 every cycle, rvalid the cycle after gnt, `i_ready`=1.
  - Requests go to 0x0, 0x4, 0x8 in order.
  - `o_valid` pulses every 3rd cycle with matching `o_pc`, and `o_pc_plus4`=`o_pc`+4.
- Backpressure:
  - Hold `i_ready`=0 for 5 cycles while `o_valid`=1.
  - `o_instr`/`o_pc` stay constant, `o_imem_req`=0 throughout, and the next request is issued only after acceptance.
- Redirect in WAIT:
  - Redirect to 0x1003 while the request at 0x8 is pending; memory returns 0xDEADBEEF 4 cycles later.
  - The word is discarded and the next request address is 0x1000.
  - `o_valid`=1 appears only for data fetched from 0x1000.
- Simultaneous events:
  - Redirect to 0x40 in the same cycle as gnt for 0xC: the 0xC response is dropped.
  - Redirect in HOLD with `i_ready`=1: the instruction is counted as accepted and the next fetch is 0x40.
- Wrap-around:
  - `RESET_PC`=32'hFFFF_FFF8.
  - Requests go to FFFF_FFF8, FFFF_FFFC, then 0x0, with `o_pc_plus4`=0 for the FFFF_FFFC instruction.
- Async reset mid-WAIT:
  - Outputs return to their reset values immediately, without waiting for a clock edge.
  - A stale rvalid 2 cycles later produces no `o_valid`.
